cpu_cpu_div_cell: RTL and testbench

Iterative radix-2 restoring divider. It is the inverse-operation companion to the CPU multiply cell and serves DIV/DIVU in the M stage. It accepts a dividend/divisor pair on a start pulse, stalls the pipeline via busy, and returns quotient and remainder with a one-cycle done strobe. Signed operation uses magnitude division with a final sign-fixup cycle.

---
 rtl/cpu_cpu_div_cell.sv | 79 +++++++
 tb/tb_cpu_cpu_div_cell.sv | 111 +++++++++++
 2 files changed

// File: rtl/cpu_cpu_div_cell.sv
// cpu_cpu_div_cell: iterative radix-2 restoring divider for DIV/DIVU with sign fixup and divide-by-zero result
module cpu_cpu_div_cell #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              M_div_start,
    input  logic              M_div_signed,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder,
    output logic              M_div_by_zero
);
    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] r, q, d, src1_orig;
    logic              neg_q, neg_r, bz;
    logic              accept, ge;
    logic [DATA_W:0]   r_sh, diff;
    logic [DATA_W-1:0] mag1, mag2;
    assign accept = M_div_start && (state == IDLE || state == DONE);
    assign mag1 = (M_div_signed && M_div_src1[DATA_W-1]) ? -M_div_src1 : M_div_src1;
    assign mag2 = (M_div_signed && M_div_src2[DATA_W-1]) ? -M_div_src2 : M_div_src2;
    assign r_sh = {r, q[DATA_W-1]};
    assign diff = r_sh - {1'b0, d};
    assign ge   = r_sh >= {1'b0, d};
    assign M_div_busy = (state == ITER) || (state == FIXUP);
    assign M_div_done = (state == DONE);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = M_div_start ? ITER : IDLE;
            ITER:    state_nxt = (cnt == CNT_W'(DATA_W - 1)) ? FIXUP : ITER;
            FIXUP:   state_nxt = DONE;
            default: state_nxt = M_div_start ? ITER : IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt             <= '0;
            r               <= '0;
            q               <= '0;
            d               <= '0;
            src1_orig       <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bz              <= 1'b0;
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
            M_div_by_zero   <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            r         <= '0;
            q         <= mag1;
            d         <= mag2;
            src1_orig <= M_div_src1;
            neg_q     <= M_div_signed && (M_div_src1[DATA_W-1] ^ M_div_src2[DATA_W-1]);
            neg_r     <= M_div_signed && M_div_src1[DATA_W-1];
            bz        <= (M_div_src2 == '0);
        end else if (state == ITER) begin
            // r < d is invariant, so a failed trial leaves r_sh within DATA_W bits
            r   <= ge ? diff[DATA_W-1:0] : r_sh[DATA_W-1:0];
            q   <= {q[DATA_W-2:0], ge};
            cnt <= cnt + 1'b1;
        end else if (state == FIXUP) begin
            M_div_quotient  <= bz ? '1 : (neg_q ? -q : q);
            M_div_remainder <= bz ? src1_orig : (neg_r ? -r : r);
            M_div_by_zero   <= bz;
        end
    end
endmodule

// File: tb/tb_cpu_cpu_div_cell.sv
// tb_cpu_cpu_div_cell: randomized and directed checks of the divider against an arithmetic reference
module tb_cpu_cpu_div_cell;
    logic        clk = 0, reset = 1;
    logic        start = 0, sgn = 0;
    logic [31:0] src1 = 0, src2 = 0;
    logic        busy, done, by_zero;
    logic [31:0] quot, rem;
    int          vectors = 0, miscompares = 0;

    cpu_cpu_div_cell dut (
        .clk(clk), .reset(reset), .M_div_start(start), .M_div_signed(sgn),
        .M_div_src1(src1), .M_div_src2(src2), .M_div_busy(busy), .M_div_done(done),
        .M_div_quotient(quot), .M_div_remainder(rem), .M_div_by_zero(by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 0) return {1'b1, 32'hFFFF_FFFF, a};
        if (!s) return {1'b0, a / b, a % b};
        sa = $signed(a);
        sb = $signed(b);
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, qq[31:0], rr[31:0]};
    endfunction

    // Entered at a negedge; leaves at the negedge of the done cycle.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit stray);
        logic [64:0] e;
        e = ref_div(s, a, b);
        sgn = s; src1 = a; src2 = b; start = 1;
        @(posedge clk);
        #1 start = 0; src1 = $urandom; src2 = $urandom; sgn = $urandom_range(0, 1);
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            check($sformatf("busy_phase k=%0d", k), {62'd0, busy, done}, 64'd2);
            if (stray && k == 10) begin start = 1; src1 = 7; src2 = 1; end
            if (stray && k == 11) start = 0;
        end
        @(negedge clk);
        check("done_cycle", {62'd0, busy, done}, 64'd1);
        check($sformatf("quot %h/%h s=%0b", a, b, s), {32'd0, quot}, {32'd0, e[63:32]});
        check($sformatf("rem %h/%h s=%0b", a, b, s), {32'd0, rem}, {32'd0, e[31:0]});
        check("by_zero", {63'd0, by_zero}, {63'd0, e[64]});
    endtask

    initial begin
        #1 check("reset_out", {busy, done, by_zero, quot, rem}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        do_op(0, 100, 7, 0);
        @(negedge clk);
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
        check("hold_quot", {32'd0, quot}, 64'd14);
        do_op(1, 32'hFFFF_FF9C, 7, 0);
        @(negedge clk);
        do_op(1, 100, 32'hFFFF_FFF9, 0);
        @(negedge clk);
        do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        do_op(1, 1234, 0, 0);
        @(negedge clk);
        do_op(0, 1234, 0, 0);
        @(negedge clk);
        sgn = 0; src1 = 32'hFFFF_FFFF; src2 = 3; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (11) @(negedge clk);
        reset = 1;
        #1 check("async_reset", {busy, done, by_zero, quot, rem}, 64'd0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) check("abandoned_op", {62'd0, busy, done}, 64'd0);
        end
        check("quiet_after_reset", {62'd0, busy, done}, 64'd0);
        do_op(0, 9, 3, 0);
        @(negedge clk);
        do_op(0, 17, 4, 0);
        do_op(0, 50, 5, 1);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 20);
                1: b = 0;
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if (i % 7 == 0) a = 32'h8000_0000;
            do_op($urandom_range(0, 1), a, b, i % 5 == 0);
            if (i % 3 != 0) @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
